// File: rtl/decode_pkg.sv
// Shared constants for the instruction decode stage: class indices and default widths.
package decode_pkg;

  localparam int INSTR_W_DEF = 8;
  localparam int CLASS_W_DEF = 2;
  localparam int FIELD_W_DEF = 3;
  localparam int CNT_W_DEF   = 16;

  localparam int CLS_IMM  = 0;
  localparam int CLS_CALC = 1;
  localparam int CLS_COPY = 2;
  localparam int CLS_COND = 3;

endpackage

// File: rtl/class_decode.sv
// Combinational split of a raw opcode into one-hot class, immediate and register/op fields.
module class_decode
  import decode_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int CLASS_W = CLASS_W_DEF,
  parameter int FIELD_W = FIELD_W_DEF
) (
  input  logic [INSTR_W-1:0]         instr,
  output logic [(2**CLASS_W)-1:0]    cls_onehot,
  output logic [INSTR_W-CLASS_W-1:0] imm,
  output logic [FIELD_W-1:0]         src,
  output logic [FIELD_W-1:0]         dst_op
);

  always_comb begin
    cls_onehot = '0;
    cls_onehot[instr[INSTR_W-1 -: CLASS_W]] = 1'b1;
  end

  // Fields overlap the immediate; which one is meaningful depends on the class.
  assign imm    = instr[INSTR_W-CLASS_W-1:0];
  assign src    = instr[2*FIELD_W-1:FIELD_W];
  assign dst_op = instr[FIELD_W-1:0];

endmodule

// File: rtl/instr_decode_stage.sv
// One-entry registered decode stage with valid/ready handshake and flush.
// Optional per-class take counters are enabled by defining DECODE_STATS_EN.
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int CLASS_W = CLASS_W_DEF,
  parameter int FIELD_W = FIELD_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INSTR_W-1:0]            instr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [(2**CLASS_W)-1:0]       cls_onehot,
  output logic [INSTR_W-CLASS_W-1:0]    imm,
  output logic [FIELD_W-1:0]            src,
`ifdef DECODE_STATS_EN
  output logic [(2**CLASS_W)*CNT_W-1:0] stat_cnt,
`endif
  output logic [FIELD_W-1:0]            dst_op
);

  localparam int NCLASS = 2**CLASS_W;

  logic [NCLASS-1:0]          cls_p0;
  logic [INSTR_W-CLASS_W-1:0] imm_p0;
  logic [FIELD_W-1:0]         src_p0;
  logic [FIELD_W-1:0]         dst_p0;

  logic                       vld_p1;
  logic [NCLASS-1:0]          cls_p1;
  logic [INSTR_W-CLASS_W-1:0] imm_p1;
  logic [FIELD_W-1:0]         src_p1;
  logic [FIELD_W-1:0]         dst_p1;

  logic accept;
  logic take;

  class_decode #(
    .INSTR_W (INSTR_W),
    .CLASS_W (CLASS_W),
    .FIELD_W (FIELD_W)
  ) u_class_decode (
    .instr      (instr),
    .cls_onehot (cls_p0),
    .imm        (imm_p0),
    .src        (src_p0),
    .dst_op     (dst_p0)
  );

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign take     = vld_p1 && out_ready;

  // p0 -> p1: decode register; data only moves on accept and is otherwise held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      cls_p1 <= '0;
      imm_p1 <= '0;
      src_p1 <= '0;
      dst_p1 <= '0;
    end else begin
      if (flush) begin
        vld_p1 <= 1'b0;
      end else if (accept) begin
        vld_p1 <= 1'b1;
      end else if (take) begin
        vld_p1 <= 1'b0;
      end
      if (accept) begin
        cls_p1 <= cls_p0;
        imm_p1 <= imm_p0;
        src_p1 <= src_p0;
        dst_p1 <= dst_p0;
      end
    end
  end

  assign out_valid  = vld_p1;
  assign cls_onehot = cls_p1;
  assign imm        = imm_p1;
  assign src        = src_p1;
  assign dst_op     = dst_p1;

`ifdef DECODE_STATS_EN
  logic [CNT_W-1:0] cnt_p2 [NCLASS];

  // Each counter tracks takes of its class and sticks at all-ones; flush leaves it alone.
  for (genvar c = 0; c < NCLASS; c++) begin : g_stat
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_p2[c] <= '0;
      end else if (take && cls_p1[c] && (cnt_p2[c] != {CNT_W{1'b1}})) begin
        cnt_p2[c] <= cnt_p2[c] + 1'b1;
      end
    end
    assign stat_cnt[c*CNT_W +: CNT_W] = cnt_p2[c];
  end
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage; counter checks run when DECODE_STATS_EN is defined.
module tb_instr_decode_stage;
  import decode_pkg::*;

  localparam int INSTR_W = 8;
  localparam int CLASS_W = 2;
  localparam int FIELD_W = 3;
`ifdef DECODE_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif
  localparam int NCLASS = 2**CLASS_W;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [INSTR_W-1:0]         instr;
  logic                       out_valid;
  logic                       out_ready;
  logic [NCLASS-1:0]          cls_onehot;
  logic [INSTR_W-CLASS_W-1:0] imm;
  logic [FIELD_W-1:0]         src;
  logic [FIELD_W-1:0]         dst_op;
`ifdef DECODE_STATS_EN
  logic [NCLASS*CNT_W-1:0]    stat_cnt;
`endif

  int evaluated = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  instr_decode_stage #(
    .INSTR_W (INSTR_W),
    .CLASS_W (CLASS_W),
    .FIELD_W (FIELD_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cls_onehot (cls_onehot),
    .imm        (imm),
    .src        (src),
`ifdef DECODE_STATS_EN
    .stat_cnt   (stat_cnt),
`endif
    .dst_op     (dst_op)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] c,
                         input logic [5:0] i, input logic [2:0] s, input logic [2:0] d);
    chk({tag, ".out_valid"},  32'(out_valid),  32'(v));
    chk({tag, ".cls_onehot"}, 32'(cls_onehot), 32'(c));
    chk({tag, ".imm"},        32'(imm),        32'(i));
    chk({tag, ".src"},        32'(src),        32'(s));
    chk({tag, ".dst_op"},     32'(dst_op),     32'(d));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = 8'h00; out_ready = 1'b0;
    step();
    chk_out("reset", 1'b0, 4'b0000, 6'h00, 3'd0, 3'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
`ifdef DECODE_STATS_EN
    chk("reset.stat_cnt", 32'(stat_cnt), 32'h00);
`endif
    rst = 1'b0;

    // immediate class
    in_valid = 1'b1; instr = 8'h3F; out_ready = 1'b1;
    step();
    chk_out("imm3f", 1'b1, 4'b0001, 6'h3F, 3'd7, 3'd7);

    // calculation, back-to-back
    instr = 8'h45;
    step();
    chk_out("calc45", 1'b1, 4'b0010, 6'h05, 3'd0, 3'd5);

    // copy
    instr = 8'h9A;
    step();
    chk_out("copy9a", 1'b1, 4'b0100, 6'h1A, 3'd3, 3'd2);

    // stall with 0x9A held while 0x45 waits at the input
    out_ready = 1'b0; instr = 8'h45;
    #1;
    chk("stall.in_ready0", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out("stall_hold", 1'b1, 4'b0100, 6'h1A, 3'd3, 3'd2);
      chk("stall.in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("release.in_ready", 32'(in_ready), 32'd1);
    step();
    chk_out("nobubble45", 1'b1, 4'b0010, 6'h05, 3'd0, 3'd5);

    // condition
    instr = 8'hC4;
    step();
    chk_out("condc4", 1'b1, 4'b1000, 6'h04, 3'd0, 3'd4);

    // flush beats the accept of 0x01; data keeps the 0xC4 decode
    flush = 1'b1; instr = 8'h01;
    step();
    chk_out("flush", 1'b0, 4'b1000, 6'h04, 3'd0, 3'd4);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk_out("postflush", 1'b0, 4'b1000, 6'h04, 3'd0, 3'd4);

    // hold 0x9A un-taken, then reset between edges
    in_valid = 1'b1; instr = 8'h9A;
    step();
    chk_out("prerst", 1'b1, 4'b0100, 6'h1A, 3'd3, 3'd2);
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_out("asyncrst", 1'b0, 4'b0000, 6'h00, 3'd0, 3'd0);
`ifdef DECODE_STATS_EN
    chk("asyncrst.stat_cnt", 32'(stat_cnt), 32'h00);
`endif
    #1;
    rst = 1'b0;

    // first edge after reset accepts; then five copy takes in total
    in_valid = 1'b1; instr = 8'h9A; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_out("copyrun", 1'b1, 4'b0100, 6'h1A, 3'd3, 3'd2);
    end
    in_valid = 1'b0;
    step();
    chk("drain.out_valid", 32'(out_valid), 32'd0);
`ifdef DECODE_STATS_EN
    // copy counter saturates at 3; others untouched, dropped entry never counted
    chk("stat.imm",  32'(stat_cnt[CLS_IMM*CNT_W  +: CNT_W]), 32'd0);
    chk("stat.calc", 32'(stat_cnt[CLS_CALC*CNT_W +: CNT_W]), 32'd0);
    chk("stat.copy", 32'(stat_cnt[CLS_COPY*CNT_W +: CNT_W]), 32'd3);
    chk("stat.cond", 32'(stat_cnt[CLS_COND*CNT_W +: CNT_W]), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("stat.flushkeep", 32'(stat_cnt), 32'h30);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 The block SHALL have parameter INSTR_W, default 8: instruction word width.
REQ-002 The block SHALL have parameter CLASS_W, default 2: number of class-select MSBs, giving NCLASS = 2**CLASS_W classes.
REQ-003 The block SHALL have parameter FIELD_W, default 3: register/op field width; legal only when INSTR_W >= CLASS_W + 2*FIELD_W.
REQ-004 The block SHALL have parameter CNT_W, default 16: statistics counter width.
REQ-005 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 The block SHALL have port flush, input, 1: discard the held decode.
REQ-008 The block SHALL have port in_valid, input, 1: instr is valid.
REQ-009 The block SHALL have port in_ready, output, 1: the stage accepts instr this cycle.
REQ-010 The block SHALL have port instr, input, INSTR_W: raw opcode.
REQ-011 The block SHALL have port out_valid, output, 1: decoded fields are valid.
REQ-012 The block SHALL have port out_ready, input, 1: consumer takes the decode.
REQ-013 The block SHALL have port cls_onehot, output, NCLASS: one-hot class (bit0 immediate, bit1 calculation, bit2 copy, bit3 condition for CLASS_W=2).
REQ-014 The block SHALL have port imm, output, INSTR_W-CLASS_W: low bits, zero-extended immediate.
REQ-015 The block SHALL have port src, output, FIELD_W: instr[2*FIELD_W-1:FIELD_W].
REQ-016 The block SHALL have port dst_op, output, FIELD_W: instr[FIELD_W-1:0]; dst for copy, ALU op for calculation, condition code for condition.

Function
REQ-017 The stage SHALL be a one-entry registered pipeline stage with 1-cycle latency from accepted input to out_valid.
REQ-018 The stage SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-019 On an accept (in_valid && in_ready && !flush), all outputs SHALL load the decode of instr, and out_valid SHALL be 1 next cycle.
REQ-020 On a take (out_valid && out_ready) with no accept, out_valid SHALL clear next cycle.
REQ-021 While out_valid=1 and out_ready=0, all outputs SHALL hold unchanged.
REQ-022 A simultaneous take and accept SHALL replace the held entry with no bubble.
REQ-023 cls_onehot SHALL have exactly one bit set whenever out_valid=1, selected by instr[INSTR_W-1 -: CLASS_W].
REQ-024 Flush SHALL clear out_valid next cycle and SHALL block the accept in the same cycle; it overrides any accept.
REQ-025 Data outputs SHALL retain their old values when out_valid=0; consumers ignore them.

Reset
REQ-026 rst=1 SHALL immediately force out_valid=0, cls_onehot=0, imm=0, src=0, dst_op=0, and all counters to 0.
REQ-027 Reset mid-transfer SHALL drop the held entry, and no take SHALL be reported for it.
REQ-028 The first accept SHALL be possible on the first clk edge after rst deasserts.

Configuration
REQ-029 With macro DECODE_STATS_EN defined, the block SHALL add output stat_cnt, NCLASS*CNT_W wide, holding one counter per class.
REQ-030 With DECODE_STATS_EN defined, each counter SHALL increment on each take of that class and SHALL saturate at all-ones.
REQ-031 With DECODE_STATS_EN defined, flush SHALL not clear the counters.
REQ-032 Without DECODE_STATS_EN, the port and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 Package decode_pkg SHALL hold the class index constants (CLS_IMM=0, CLS_CALC=1, CLS_COPY=2, CLS_COND=3) and the default widths.
REQ-034 The combinational class/field split SHALL be sub-module class_decode, with instr in and cls_onehot/imm/src/dst_op out; the stage registers its outputs.

Verification
REQ-035 The bench SHALL cover: instr=0x3F accepted -> next cycle out_valid=1, cls_onehot=0001, imm=0x3F.
REQ-036 The bench SHALL cover: instr=0x45 -> cls_onehot=0010, dst_op=5; instr=0x9A -> cls_onehot=0100, src=3, dst_op=2; instr=0xC4 -> cls_onehot=1000, dst_op=4.
REQ-037 The bench SHALL cover: out_ready=0 for 3 cycles with 0x9A held -> in_ready=0, outputs stable; out_ready=1 with new 0x45 valid -> 0x45 decode next cycle, no bubble.
REQ-038 The bench SHALL cover: flush asserted with in_valid=1, instr=0x01 -> out_valid=0 next cycle, 0x01 never presented.
REQ-039 The bench SHALL cover: rst pulsed between clock edges while out_valid=1 -> out_valid=0 immediately, all outputs 0.
REQ-040 The bench SHALL cover, with DECODE_STATS_EN and CNT_W=2: 5 takes of class copy -> copy counter reads 3, all other counters 0.
